vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 800x600@72 Hz SVGA raster timing and feeds `frame_scaler`. It supplies the scaler's `pixel_x`/`pixel_y` coordinates, drives hsync/vsync/data-enable to the VGA pins, and provides frame-level status to game logic. Sync and data-enable are delayed through a configurable pipeline so they stay aligned with the scaler's registered colour output.

## Interface
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch
- `H_SYNC`, 120: hsync width
- `H_BP`, 64: horizontal back porch
- `V_ACTIVE`, 600: visible lines
- `V_FP`, 37: vertical front porch
- `V_SYNC`, 6: vsync width
- `V_BP`, 23: vertical back porch
- `H_POL`, 1: hsync active level (1 = positive)
- `V_POL`, 1: vsync active level
- `PIPE_DELAY`, 2: pix_en beats of delay on hsync/vsync/de (0..4); 2 matches BRAM read plus scaler colour register
- `clk` in 1: pixel-domain clock (50 MHz nominal)
- `reset_n` in 1: asynchronous, active-low reset
- `pix_en` in 1: pixel advance enable; tie high when clk is the pixel clock
- `pixel_x` out 10: current column, 0..H_ACTIVE-1; 0 during blanking
- `pixel_y` out 10: current row, 0..V_ACTIVE-1; 0 during blanking
- `hsync` out 1: delayed horizontal sync
- `vsync` out 1: delayed vertical sync
- `de` out 1: delayed data enable
- `vblank` out 1: undelayed, high while v_cnt >= V_ACTIVE
- `frame_start` out 1: one-clk pulse at the start of each frame

## Operation
- H_TOTAL = sum of the H params = 1040. V_TOTAL = sum of the V params = 666.
- Counters h_cnt and v_cnt are 11 bits wide, registered, and advance only on clk edges with pix_en=1.
- h_cnt wraps H_TOTAL-1 -> 0. On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- active_raw = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hsync_raw is H_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (856..975), else ~H_POL.
- vsync_raw is V_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (637..642), else ~V_POL.
  - vsync_raw is evaluated on v_cnt only; it is line-aligned and changes at h_cnt=0.
- pixel_x = h_cnt[9:0] when h_cnt < H_ACTIVE, else 0.
- pixel_y = v_cnt[9:0] when v_cnt < V_ACTIVE, else 0.
  - Both are combinational from the counter registers.
  - Blanking forces address 0 so the scaler pre-fetches a harmless location.
- Delay line: {hsync_raw, vsync_raw, active_raw} shift through PIPE_DELAY registers.
  - All stages advance only on pix_en.
  - PIPE_DELAY=0 drives the outputs directly from the raw signals.
- frame_start is registered. It goes high for exactly one clk cycle after a pix_en edge that moves the counters from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is low otherwise, including while pix_en=0.
- vblank is combinational from v_cnt.

## Timing
- Reset values (asserted or mid-frame reset):
  - h_cnt=0, v_cnt=0, so pixel_x=0 and pixel_y=0.
  - All delay stages are cleared to inactive: hsync=~H_POL, vsync=~V_POL, de=0.
  - frame_start=0, vblank=0.
  - Reset aborts the frame immediately; there is no partial-line recovery.
- After reset release, the first pix_en edge moves h_cnt to 1. Pixel (0,0) is presented during reset and in the first cycle after release.
- No frame_start pulse is issued for the frame entered via reset. The first pulse comes after one full frame (H_TOTAL*V_TOTAL = 692640 beats).
- Latency: de/hsync/vsync lag pixel_x/pixel_y by exactly PIPE_DELAY pix_en beats. With default params, de first rises at beat 2 after release.
- pix_en=0 freezes the counters, coordinate outputs, delay line and vblank. frame_start is forced low.
- Line period is 1040 beats and frame period is 692640 beats: 72.19 Hz at 50 MHz.

## Test plan
- Reset: assert reset_n=0 mid-line (h_cnt≈500, v_cnt≈300) -> same cycle pixel_x=0, pixel_y=0, de=0, hsync=0, vsync=0, vblank=0; after release, de rises at beat 2 with pix_en=1.
- Line timing, pix_en=1, defaults: hsync high for exactly 120 clks, first high at beat 858 of each line (856+2); de high for 800 clks per line; pixel_x counts 0..799 then reads 0 for 240 clks.
- Frame timing: vblank high from line 600 through 665 (66 lines). vsync high for 6 lines, starting at line 637 + 2 beats. frame_start pulses once every 692640 clks and is high exactly 1 clk.
- pix_en gating: drive pix_en in a 1-of-2 pattern -> all periods double in clk cycles; outputs hold while pix_en=0; frame_start width stays 1 clk.
- PIPE_DELAY=0 build: de equals active_raw in the same cycle as pixel_x; hsync rises in the same cycle as h_cnt=856.
- Polarity build H_POL=0, V_POL=0: reset drives hsync=1 and vsync=1; sync pulses go low with the same widths and positions as the default build.

Source files
------------

// File: rtl/vga_timing_gen.sv
// SVGA raster timing generator: 11-bit h/v counters, blank-forced coordinates,
// and a pix_en-gated delay line that aligns sync/de with the downstream colour pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter bit H_POL      = 1'b1,
    parameter bit V_POL      = 1'b1,
    parameter int PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       vblank,
    output logic       frame_start
);

    localparam logic [10:0] H_ACT_C   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_LO = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_HI = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT_C   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_LO = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_HI = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Inactive level of the delay line: sync deasserted, de low.
    localparam logic [2:0] IDLE = {~H_POL, ~V_POL, 1'b0};

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_last;
    logic        v_last;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        active_raw;
    logic [2:0]  raw;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last && v_last;
            if (pix_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 11'd1;
                end else begin
                    h_cnt <= h_cnt + 11'd1;
                end
            end
        end
    end

    // Raw timing decode straight off the counter registers
    assign active_raw = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hsync_raw  = ((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI)) ? H_POL : ~H_POL;
    assign vsync_raw  = ((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI)) ? V_POL : ~V_POL;
    assign raw        = {hsync_raw, vsync_raw, active_raw};

    // Blanking parks the scaler address at 0 so its prefetch is harmless.
    assign pixel_x = (h_cnt < H_ACT_C) ? h_cnt[9:0] : '0;
    assign pixel_y = (v_cnt < V_ACT_C) ? v_cnt[9:0] : '0;
    assign vblank  = (v_cnt >= V_ACT_C);

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign {hsync, vsync, de} = raw;
        end else begin : g_dly
            logic [2:0] dly_p [PIPE_DELAY];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_DELAY; i++) dly_p[i] <= IDLE;
                end else if (pix_en) begin
                    dly_p[0] <= raw;
                    for (int i = 1; i < PIPE_DELAY; i++) dly_p[i] <= dly_p[i-1];
                end
            end

            assign {hsync, vsync, de} = dly_p[PIPE_DELAY-1];
        end
    endgenerate

endmodule
